// File: rtl/shift_pkg.sv
// Shared operation-mode encodings for the universal shift register.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // Modes that advance the shift counter.
  function automatic logic is_count_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
           (mode == MODE_ROR) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_cell.sv
// One bit of the universal shift register: mode-selected next-state mux plus
// a flip-flop with synchronous reset and clock enable.
module shift_reg_cell
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] mode,
  input  logic       shl_in,  // bit arriving on shift left (lower neighbour or sin_l)
  input  logic       shr_in,  // bit arriving on shift right (upper neighbour or sin_r)
  input  logic       rol_in,  // bit arriving on rotate left
  input  logic       ror_in,  // bit arriving on rotate right
  input  logic       asr_in,  // bit arriving on arithmetic right shift
  input  logic       ld,
  output logic       q
);

  logic q_next;

  // Select the next value for this bit from the operation mode.
  always_comb begin
    q_next = q;
    unique case (mode)
      MODE_HOLD: q_next = q;
      MODE_SHL:  q_next = shl_in;
      MODE_SHR:  q_next = shr_in;
      MODE_LOAD: q_next = ld;
      MODE_ROL:  q_next = rol_in;
      MODE_ROR:  q_next = ror_in;
      MODE_ASR:  q_next = asr_in;
      MODE_CLR:  q_next = 1'b0;
    endcase
  end

  // Bit storage: reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Parametrised universal shift register with shift counter and word-done pulse.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(WIDTH);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic shl_in, shr_in, rol_in, ror_in, asr_in;

    if (i == 0) begin : g_lsb
      assign shl_in = sin_l;
      assign rol_in = q[WIDTH-1];
    end else begin : g_low
      assign shl_in = q[i-1];
      assign rol_in = q[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign shr_in = sin_r;
      assign ror_in = q[0];
      assign asr_in = q[WIDTH-1];  // sign bit replicates
    end else begin : g_high
      assign shr_in = q[i+1];
      assign ror_in = q[i+1];
      assign asr_in = q[i+1];
    end

    shift_reg_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .shl_in (shl_in),
      .shr_in (shr_in),
      .rol_in (rol_in),
      .ror_in (ror_in),
      .asr_in (asr_in),
      .ld     (d[i]),
      .q      (q[i])
    );
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

  logic [CNT_W-1:0] cnt_next;
  logic             done_next;

  // Saturating shift count; done fires only on the step that reaches WIDTH.
  always_comb begin
    cnt_next  = cnt;
    done_next = 1'b0;
    if (en) begin
      if (mode == MODE_LOAD || mode == MODE_CLR) begin
        cnt_next = '0;
      end else if (is_count_mode(mode) && (cnt < CntMax)) begin
        cnt_next  = cnt + 1'b1;
        done_next = (cnt == CntMax - 1'b1);
      end
    end
  end

  // Counter and done registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      done <= done_next;
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench: 4-bit and 8-bit instances driven in lockstep, expected
// values from a behavioural model queued at drive time and compared after the edge.
module tb_shift_reg_univ;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [3:0] d4, q4;
  logic [7:0] d8, q8;
  logic [2:0] cnt4;
  logic [3:0] cnt8;
  logic       sl4, sr4, done4, sl8, sr8, done8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d4), .q(q4), .sout_l(sl4), .sout_r(sr4), .cnt(cnt4), .done(done4)
  );

  shift_reg_univ #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d8), .q(q8), .sout_l(sl8), .sout_r(sr8), .cnt(cnt8), .done(done8)
  );

  typedef struct {
    string      tag;
    bit         is8;
    logic [7:0] q;
    logic [3:0] cnt;
    logic       done;
  } exp_t;

  exp_t sb[$];

  // Model state per instance.
  logic [7:0] m_q[2];
  logic [3:0] m_cnt[2];
  logic       m_done[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_q(input logic [7:0] q, input int w,
                                         input logic [2:0] md, input logic sl,
                                         input logic sr, input logic [7:0] dv);
    logic [7:0] mask, n, msb;
    mask = 8'((1 << w) - 1);
    msb  = 8'(1 << (w - 1));
    case (md)
      MODE_SHL:  n = (q << 1) | {7'd0, sl};
      MODE_SHR:  n = (q >> 1) | (sr ? msb : 8'd0);
      MODE_LOAD: n = dv;
      MODE_ROL:  n = (q << 1) | {7'd0, q[w-1]};
      MODE_ROR:  n = (q >> 1) | (q[0] ? msb : 8'd0);
      MODE_ASR:  n = (q >> 1) | (q[w-1] ? msb : 8'd0);
      MODE_CLR:  n = 8'd0;
      default:   n = q;
    endcase
    return n & mask;
  endfunction

  // Apply one clock of stimulus and check both instances after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] md,
                      input logic sl, input logic sr, input logic [3:0] dv4,
                      input logic [7:0] dv8);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = md; sin_l = sl; sin_r = sr; d4 = dv4; d8 = dv8;
    for (int k = 0; k < 2; k++) begin
      int w;
      logic counting;
      w = (k == 0) ? 4 : 8;
      counting = e && (md == MODE_SHL || md == MODE_SHR || md == MODE_ROL ||
                       md == MODE_ROR || md == MODE_ASR);
      if (r) begin
        m_q[k] = 8'd0; m_cnt[k] = 4'd0; m_done[k] = 1'b0;
      end else if (!e) begin
        m_done[k] = 1'b0;
      end else begin
        m_q[k]    = model_q(m_q[k], w, md, sl, sr, (k == 0) ? {4'd0, dv4} : dv8);
        m_done[k] = counting && (int'(m_cnt[k]) == w - 1);
        if (md == MODE_LOAD || md == MODE_CLR) m_cnt[k] = 4'd0;
        else if (counting && int'(m_cnt[k]) < w) m_cnt[k] = m_cnt[k] + 4'd1;
      end
      x.tag = tag; x.is8 = (k == 1); x.q = m_q[k]; x.cnt = m_cnt[k]; x.done = m_done[k];
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.is8) begin
        chk({x.tag, "/q8"}, q8, x.q);
        chk({x.tag, "/cnt8"}, {4'd0, cnt8}, {4'd0, x.cnt});
        chk({x.tag, "/done8"}, {7'd0, done8}, {7'd0, x.done});
        chk({x.tag, "/sout8"}, {6'd0, sl8, sr8}, {6'd0, x.q[7], x.q[0]});
      end else begin
        chk({x.tag, "/q4"}, {4'd0, q4}, x.q);
        chk({x.tag, "/cnt4"}, {5'd0, cnt4}, {4'd0, x.cnt});
        chk({x.tag, "/done4"}, {7'd0, done4}, {7'd0, x.done});
        chk({x.tag, "/sout4"}, {6'd0, sl4, sr4}, {6'd0, x.q[3], x.q[0]});
      end
    end
  endtask

  initial begin
    logic [3:0] shr_q[4];
    logic       shr_sr[4];
    logic [3:0] shl_q[4];
    logic       shl_in[4];
    logic [3:0] rol_q[4];
    shr_q  = '{4'b0101, 4'b0010, 4'b0001, 4'b0000};
    shr_sr = '{1'b1, 1'b1, 1'b0, 1'b1};
    shl_q  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
    shl_in = '{1'b1, 1'b0, 1'b1, 1'b1};
    rol_q  = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
    m_q = '{8'd0, 8'd0}; m_cnt = '{4'd0, 4'd0}; m_done = '{1'b0, 1'b0};
    rst = 1'b1; en = 1'b1; mode = MODE_HOLD; sin_l = 1'b0; sin_r = 1'b0;
    d4 = 4'h0; d8 = 8'h00;

    // Reset beats LOAD.
    step("reset", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 4'hF, 8'hFF);
    chk("reset_q", {4'd0, q4}, 8'h00);
    chk("reset_cnt", {5'd0, cnt4}, 8'h00);

    // LOAD then four right shifts.
    step("load_1011", 1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1011, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("shr_sout_r_pre", {7'd0, sr4}, {7'd0, shr_sr[i]});
      step("shr", 1'b0, 1'b1, MODE_SHR, 1'b0, 1'b0, 4'h0, 8'h00);
      chk("shr_q", {4'd0, q4}, {4'd0, shr_q[i]});
    end
    chk("shr_done", {7'd0, done4}, 8'h01);
    chk("shr_cnt", {5'd0, cnt4}, 8'h04);

    // CLR while done is high, then four left shifts and one saturated shift.
    step("clr", 1'b0, 1'b1, MODE_CLR, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("clr_done_drop", {7'd0, done4}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step("shl", 1'b0, 1'b1, MODE_SHL, shl_in[i], 1'b0, 4'h0, 8'h00);
      chk("shl_q", {4'd0, q4}, {4'd0, shl_q[i]});
    end
    chk("shl_done", {7'd0, done4}, 8'h01);
    step("shl_sat", 1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("shl_sat_cnt", {5'd0, cnt4}, 8'h04);
    chk("shl_sat_done", {7'd0, done4}, 8'h00);

    // LOAD after saturation, rotate a full word, then one rotate right.
    step("load_1001", 1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1001, 8'h00);
    chk("load_cnt0", {5'd0, cnt4}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step("rol", 1'b0, 1'b1, MODE_ROL, 1'b0, 1'b0, 4'h0, 8'h00);
      chk("rol_q", {4'd0, q4}, {4'd0, rol_q[i]});
    end
    chk("rol_done", {7'd0, done4}, 8'h01);
    step("ror", 1'b0, 1'b1, MODE_ROR, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("ror_q", {4'd0, q4}, 8'b1100);

    // Arithmetic shift then freeze with en=0.
    step("load_1000", 1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 4'b1000, 8'h00);
    step("asr1", 1'b0, 1'b1, MODE_ASR, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("asr1_q", {4'd0, q4}, 8'b1100);
    step("asr2", 1'b0, 1'b1, MODE_ASR, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("asr2_q", {4'd0, q4}, 8'b1110);
    for (int i = 0; i < 3; i++) begin
      step("en_off", 1'b0, 1'b0, MODE_SHL, 1'b1, 1'b1, 4'h0, 8'h00);
    end
    chk("en_off_q", {4'd0, q4}, 8'b1110);
    chk("en_off_cnt", {5'd0, cnt4}, 8'h02);

    // Reset mid-sequence with en=1 and a shift mode.
    step("load_1111", 1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 4'hF, 8'h00);
    step("shl_a", 1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 4'h0, 8'h00);
    step("shl_b", 1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 4'h0, 8'h00);
    step("mid_rst", 1'b1, 1'b1, MODE_SHL, 1'b1, 1'b1, 4'h0, 8'h00);
    chk("mid_rst_q", {4'd0, q4}, 8'h00);
    chk("mid_rst_cnt", {5'd0, cnt4}, 8'h00);

    // Eight-bit instance: LOAD A5 then eight right shifts.
    step("load_a5", 1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 4'h0, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      step("shr8", 1'b0, 1'b1, MODE_SHR, 1'b0, 1'b0, 4'h0, 8'h00);
      if (i == 6) chk("shr8_no_early_done", {7'd0, done8}, 8'h00);
    end
    chk("shr8_q", q8, 8'h00);
    chk("shr8_done", {7'd0, done8}, 8'h01);
    chk("shr8_cnt", {4'd0, cnt8}, 8'h08);
    step("hold8", 1'b0, 1'b1, MODE_HOLD, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("hold8_done_drop", {7'd0, done8}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
